// File: rtl/unidade_controle.sv
// unidade_controle: Moore control unit for the memory-sequence game.
// Sequences one round against the datapath: clear, wait for a play,
// register it, compare it, then advance or finish (hit, miss, timeout).
// Build option: define UNIDADE_CONTROLE_TIMEOUT_EN to enable the
// inactivity timeout; without it espera_jogada waits indefinitely,
// contaInativo and timeout are tied low and fim_timeout is unreachable.
//
// state          | code | meaning
// inicial        |  0   | idle after reset, waiting for iniciar
// preparacao     |  1   | clear address counter, play register, idle timer
// espera_jogada  |  2   | waiting for a play, idle timer running
// registra       |  3   | load play register, restart idle timer
// comparacao     |  4   | evaluate comparator / last-position flags
// proximo        |  5   | advance address counter
// fim_acerto     |  A   | round complete, all plays correct
// fim_erro       |  E   | round ended on a wrong play
// fim_timeout    |  D   | round ended on inactivity
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    input  logic       inativo,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraInativo,
    output logic       contaInativo,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_JOGADA = 4'h2,
        REGISTRA      = 4'h3,
        COMPARACAO    = 4'h4,
        PROXIMO       = 4'h5,
        FIM_ACERTO    = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERRO      = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    logic inativo_eff;
    logic timeout_en;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    assign inativo_eff = inativo;
    assign timeout_en  = 1'b1;
`else
    // Timeout disabled: the idle flag from the datapath is deliberately unused.
    logic unused_inativo;
    assign unused_inativo = inativo;
    assign inativo_eff    = 1'b0;
    assign timeout_en     = 1'b0;
`endif

    // State register; asynchronous reset returns to inicial immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL: begin
                estado_d = iniciar ? PREPARACAO : INICIAL;
            end
            PREPARACAO: begin
                estado_d = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // A play in the same cycle as the idle flag wins.
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else if (inativo_eff) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA_JOGADA;
                end
            end
            REGISTRA: begin
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (fimC) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                estado_d = ESPERA_JOGADA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                // Restart goes straight to preparacao, not through inicial.
                estado_d = iniciar ? PREPARACAO : estado_q;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // Moore output decode: every output depends on the current state only.
    always_comb begin
        zeraC        = 1'b0;
        contaC       = 1'b0;
        zeraR        = 1'b0;
        registraR    = 1'b0;
        zeraInativo  = 1'b0;
        contaInativo = 1'b0;
        pronto       = 1'b0;
        acertou      = 1'b0;
        errou        = 1'b0;
        timeout      = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraC       = 1'b1;
                zeraR       = 1'b1;
                zeraInativo = 1'b1;
            end
            ESPERA_JOGADA: begin
                contaInativo = timeout_en;
            end
            REGISTRA: begin
                registraR   = 1'b1;
                zeraInativo = 1'b1;
            end
            PROXIMO: begin
                contaC = 1'b1;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = timeout_en;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule
